seq_pattern_tx: RTL and testbench

Serial pattern transmitter. It accepts a PAT_W-bit pattern and a repeat count over a valid/ready handshake. It then drives the pattern MSB-first onto a 1-bit serial line, one bit per clk, for the requested number of repetitions, with a fixed idle gap between repetitions. It is the stimulus source for the team's serial pattern detectors, and the on-chip generator for test patterns such as 1010.

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_piso_shift.sv | 52 +++++
 rtl/seq_pattern_tx.sv | 153 +++++++++++++++
 tb/tb_seq_pattern_tx.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants for the serial pattern transmitter family.
// Holds the FSM state encoding and the default test pattern (1010)
// that the transmitter substitutes for an all-zero pattern.
package seq_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] GAP   = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  localparam logic [3:0] SEQ_PAT_1010 = 4'b1010;

endpackage

// File: rtl/seq_piso_shift.sv
// Parallel-in, serial-out shifter, MSB first.
// Ports:
//   clk, rst     - clock and asynchronous active-high reset
//   load_i       - load data_i into the shifter (wins over shift_i)
//   shift_i      - advance to the next lower bit
//   data_i       - parallel pattern to load
//   msb_next_o   - the bit that will be at the head after this edge
//   last_o       - the bit currently at the head is the final one
module seq_piso_shift #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [PAT_W-1:0] data_i,
  output logic             msb_next_o,
  output logic             last_o
);

  localparam int IDX_W = $clog2(PAT_W);

  logic [PAT_W-1:0] sreg_q;
  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      idx_q  <= '0;
    end else if (load_i) begin
      sreg_q <= data_i;
      idx_q  <= IDX_W'(PAT_W - 1);
    end else if (shift_i) begin
      sreg_q <= {sreg_q[PAT_W-2:0], 1'b0};
      idx_q  <= idx_q - IDX_W'(1);
    end
  end

  // Look-ahead head bit lets the top register data_out in the same
  // cycle the shifter itself updates.
  always_comb begin
    msb_next_o = sreg_q[PAT_W-1];
    if (load_i) begin
      msb_next_o = data_i[PAT_W-1];
    end else if (shift_i) begin
      msb_next_o = sreg_q[PAT_W-2];
    end
  end

  assign last_o = (idx_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter. Accepts a pattern and repeat count over a
// valid/ready handshake, then sends the pattern MSB first, one bit per
// clock, for the requested repetitions with an idle gap in between.
// Ports:
//   clk, rst    - clock and asynchronous active-high reset
//   pat_valid   - pattern/count offered
//   pat_data    - pattern, transmitted MSB first
//   rep_count   - repetitions requested (0 means 1)
//   pat_ready   - block is idle and can accept
//   abort       - synchronous abort of the current transfer
//   data_out    - serial bit (IDLE_LEVEL when not sending)
//   data_valid  - data_out carries a pattern bit
//   busy        - transfer in progress
//   frame_done  - one-cycle pulse after the final bit
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(SEQ_PAT_1010),
  parameter int               USE_DEFAULT = 1,
  parameter int               CNT_W       = 8,
  parameter int               GAP_BITS    = 2,
  parameter logic             IDLE_LEVEL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pat_valid,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [CNT_W-1:0] rep_count,
  output logic             pat_ready,
  input  logic             abort,
  output logic             data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int GAP_CW = (GAP_BITS > 2) ? $clog2(GAP_BITS) : 1;
  localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  logic [1:0]        state_q, state_d;
  logic [PAT_W-1:0]  pat_q, pat_d, pat_eff, load_pat;
  logic [CNT_W-1:0]  reps_q, reps_d;
  logic [GAP_CW-1:0] gap_q, gap_d;
  logic              load, shift, msb_next, last_bit, accept;
  logic              data_out_q, data_valid_q, busy_q, frame_done_q;

  assign pat_ready = (state_q == IDLE);
  assign accept    = pat_valid && pat_ready;

  assign pat_eff  = ((USE_DEFAULT != 0) && (pat_data == '0)) ? DEFAULT_PAT : pat_data;
  // Fresh accepts load straight from the input; reloads after a gap use the capture.
  assign load_pat = (state_q == IDLE) ? pat_eff : pat_q;

  seq_piso_shift #(.PAT_W(PAT_W)) u_shift (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .shift_i    (shift),
    .data_i     (load_pat),
    .msb_next_o (msb_next),
    .last_o     (last_bit)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    reps_d  = reps_q;
    gap_d   = gap_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pat_d   = pat_eff;
          reps_d  = (rep_count == '0) ? CNT_W'(1) : rep_count;
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          if (reps_q > CNT_W'(1)) begin
            reps_d = reps_q - CNT_W'(1);
            if (GAP_BITS == 0) begin
              state_d = SHIFT;
              load    = 1'b1;
            end else begin
              state_d = GAP;
              gap_d   = GAP_LAST;
            end
          end else begin
            state_d = DONE;
          end
        end else begin
          shift = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = SHIFT;
          load    = 1'b1;
        end else begin
          gap_d = gap_q - GAP_CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort overrides everything outside IDLE; in IDLE an accept still goes ahead.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      load    = 1'b0;
      shift   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      reps_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      reps_q  <= reps_d;
      gap_q   <= gap_d;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q   <= IDLE_LEVEL;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      data_out_q   <= (state_d == SHIFT) ? msb_next : IDLE_LEVEL;
      data_valid_q <= (state_d == SHIFT);
      busy_q       <= (state_d != IDLE);
      frame_done_q <= (state_d == DONE);
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed testbench for seq_pattern_tx. Instance A uses the default
// parameters (USE_DEFAULT=1, GAP_BITS=2); instance B uses USE_DEFAULT=0
// and GAP_BITS=0 to cover raw zero patterns and back-to-back repeats.
// Per-cycle observation vector is {data_out, data_valid, busy, frame_done}.
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst;
  logic       patValidA, abortA;
  logic [3:0] patDataA;
  logic [7:0] repCountA;
  logic       patReadyA, dataOutA, dataValidA, busyA, frameDoneA;
  logic       patValidB, abortB;
  logic [3:0] patDataB;
  logic [7:0] repCountB;
  logic       patReadyB, dataOutB, dataValidB, busyB, frameDoneB;

  int checks = 0;
  int errors = 0;

  seq_pattern_tx dutA (
    .clk        (clk),
    .rst        (rst),
    .pat_valid  (patValidA),
    .pat_data   (patDataA),
    .rep_count  (repCountA),
    .pat_ready  (patReadyA),
    .abort      (abortA),
    .data_out   (dataOutA),
    .data_valid (dataValidA),
    .busy       (busyA),
    .frame_done (frameDoneA)
  );

  seq_pattern_tx #(.USE_DEFAULT(0), .GAP_BITS(0)) dutB (
    .clk        (clk),
    .rst        (rst),
    .pat_valid  (patValidB),
    .pat_data   (patDataB),
    .rep_count  (repCountB),
    .pat_ready  (patReadyB),
    .abort      (abortB),
    .data_out   (dataOutB),
    .data_valid (dataValidB),
    .busy       (busyB),
    .frame_done (frameDoneB)
  );

  // 10 ns clock; stimulus and sampling happen 1 ns after each rising edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a pattern for one edge; returns at the sample point of cycle 1.
  task automatic acceptA(input logic [3:0] pat, input logic [7:0] cnt);
    patValidA = 1'b1;
    patDataA  = pat;
    repCountA = cnt;
    step();
    patValidA = 1'b0;
  endtask

  task automatic acceptB(input logic [3:0] pat, input logic [7:0] cnt);
    patValidB = 1'b1;
    patDataB  = pat;
    repCountB = cnt;
    step();
    patValidB = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if ({dataOutA, dataValidA, busyA, frameDoneA, patReadyA} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL reset_A got %b exp 00001", {dataOutA, dataValidA, busyA, frameDoneA, patReadyA});
    end
    checks++;
    if ({dataOutB, dataValidB, busyB, frameDoneB, patReadyB} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL reset_B got %b exp 00001", {dataOutB, dataValidB, busyB, frameDoneB, patReadyB});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({busyA, patReadyA} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reset_release got %b exp 01", {busyA, patReadyA});
    end
  endtask

  task automatic test_basic();
    logic [4:0] expDo, expDv, expFd;
    logic [3:0] exp;
    expDo = 5'b10100;
    expDv = 5'b11110;
    expFd = 5'b00001;
    acceptA(4'b1010, 8'd1);
    for (int i = 0; i < 5; i++) begin
      exp = {expDo[4-i], expDv[4-i], 1'b1, expFd[4-i]};
      checks++;
      if ({dataOutA, dataValidA, busyA, frameDoneA} !== exp) begin
        errors++;
        $display("[TB] FAIL basic cyc%0d got %b exp %b", i + 1, {dataOutA, dataValidA, busyA, frameDoneA}, exp);
      end
      step();
    end
    checks++;
    if ({patReadyA, busyA} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL basic_ready got %b exp 10", {patReadyA, busyA});
    end
  endtask

  // 3 reps of 1101 with 2-cycle gaps: 3*4 + 2*2 + 1 = 17 cycles to frame_done.
  task automatic test_repeats();
    logic [16:0] expDo, expDv, expFd;
    logic [3:0]  exp;
    expDo = 17'b1101_00_1101_00_1101_0;
    expDv = 17'b1111_00_1111_00_1111_0;
    expFd = 17'b0000_00_0000_00_0000_1;
    acceptA(4'b1101, 8'd3);
    for (int i = 0; i < 17; i++) begin
      exp = {expDo[16-i], expDv[16-i], 1'b1, expFd[16-i]};
      checks++;
      if ({dataOutA, dataValidA, busyA, frameDoneA} !== exp) begin
        errors++;
        $display("[TB] FAIL repeats cyc%0d got %b exp %b", i + 1, {dataOutA, dataValidA, busyA, frameDoneA}, exp);
      end
      step();
    end
    checks++;
    if (patReadyA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL repeats_ready got %b exp 1", patReadyA);
    end
  endtask

  task automatic test_zero_default();
    logic [4:0] expDo, expDv, expFd;
    logic [3:0] exp;
    expDo = 5'b10100;
    expDv = 5'b11110;
    expFd = 5'b00001;
    acceptA(4'b0000, 8'd0);
    for (int i = 0; i < 5; i++) begin
      exp = {expDo[4-i], expDv[4-i], 1'b1, expFd[4-i]};
      checks++;
      if ({dataOutA, dataValidA, busyA, frameDoneA} !== exp) begin
        errors++;
        $display("[TB] FAIL zero_default cyc%0d got %b exp %b", i + 1, {dataOutA, dataValidA, busyA, frameDoneA}, exp);
      end
      step();
    end
  endtask

  task automatic test_zero_nodefault();
    logic [4:0] expDo, expDv, expFd;
    logic [3:0] exp;
    expDo = 5'b00000;
    expDv = 5'b11110;
    expFd = 5'b00001;
    acceptB(4'b0000, 8'd0);
    for (int i = 0; i < 5; i++) begin
      exp = {expDo[4-i], expDv[4-i], 1'b1, expFd[4-i]};
      checks++;
      if ({dataOutB, dataValidB, busyB, frameDoneB} !== exp) begin
        errors++;
        $display("[TB] FAIL zero_nodefault cyc%0d got %b exp %b", i + 1, {dataOutB, dataValidB, busyB, frameDoneB}, exp);
      end
      step();
    end
  endtask

  // No gap configured: two reps of 1001 run with no bubble.
  task automatic test_back_to_back();
    logic [8:0] expDo, expDv, expFd;
    logic [3:0] exp;
    expDo = 9'b1001_1001_0;
    expDv = 9'b1111_1111_0;
    expFd = 9'b0000_0000_1;
    acceptB(4'b1001, 8'd2);
    for (int i = 0; i < 9; i++) begin
      exp = {expDo[8-i], expDv[8-i], 1'b1, expFd[8-i]};
      checks++;
      if ({dataOutB, dataValidB, busyB, frameDoneB} !== exp) begin
        errors++;
        $display("[TB] FAIL back_to_back cyc%0d got %b exp %b", i + 1, {dataOutB, dataValidB, busyB, frameDoneB}, exp);
      end
      step();
    end
    checks++;
    if (patReadyB !== 1'b1) begin
      errors++;
      $display("[TB] FAIL back_to_back_ready got %b exp 1", patReadyB);
    end
  endtask

  // Abort during the 3rd bit of rep 2 (cycle 9), then restart immediately.
  task automatic test_abort();
    logic [8:0] expDo, expDv;
    logic [4:0] newDo, newDv, newFd;
    logic [3:0] exp;
    expDo = 9'b1101_00_110;
    expDv = 9'b1111_00_111;
    newDo = 5'b01100;
    newDv = 5'b11110;
    newFd = 5'b00001;
    acceptA(4'b1101, 8'd3);
    for (int i = 0; i < 9; i++) begin
      exp = {expDo[8-i], expDv[8-i], 1'b1, 1'b0};
      checks++;
      if ({dataOutA, dataValidA, busyA, frameDoneA} !== exp) begin
        errors++;
        $display("[TB] FAIL abort_pre cyc%0d got %b exp %b", i + 1, {dataOutA, dataValidA, busyA, frameDoneA}, exp);
      end
      if (i == 8) abortA = 1'b1;
      step();
    end
    abortA = 1'b0;
    checks++;
    if ({dataOutA, dataValidA, busyA, frameDoneA, patReadyA} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL abort_post got %b exp 00001", {dataOutA, dataValidA, busyA, frameDoneA, patReadyA});
    end
    acceptA(4'b0110, 8'd1);
    for (int i = 0; i < 5; i++) begin
      exp = {newDo[4-i], newDv[4-i], 1'b1, newFd[4-i]};
      checks++;
      if ({dataOutA, dataValidA, busyA, frameDoneA} !== exp) begin
        errors++;
        $display("[TB] FAIL abort_restart cyc%0d got %b exp %b", i + 1, {dataOutA, dataValidA, busyA, frameDoneA}, exp);
      end
      step();
    end
  endtask

  // pat_valid held high with changing data: only accept-edge values are sent.
  task automatic test_handshake();
    logic [4:0] firstDo, secondDo, expDv, expFd;
    logic [3:0] exp;
    firstDo  = 5'b10110;
    secondDo = 5'b01110;
    expDv    = 5'b11110;
    expFd    = 5'b00001;
    patValidA = 1'b1;
    patDataA  = 4'b1011;
    repCountA = 8'd1;
    step();
    for (int i = 0; i < 5; i++) begin
      exp = {firstDo[4-i], expDv[4-i], 1'b1, expFd[4-i]};
      checks++;
      if ({dataOutA, dataValidA, busyA, frameDoneA} !== exp) begin
        errors++;
        $display("[TB] FAIL handshake_first cyc%0d got %b exp %b", i + 1, {dataOutA, dataValidA, busyA, frameDoneA}, exp);
      end
      patDataA = 4'(i + 2);
      step();
    end
    checks++;
    if (patReadyA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL handshake_ready got %b exp 1", patReadyA);
    end
    patDataA = 4'b0111;
    step();
    patValidA = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp = {secondDo[4-i], expDv[4-i], 1'b1, expFd[4-i]};
      checks++;
      if ({dataOutA, dataValidA, busyA, frameDoneA} !== exp) begin
        errors++;
        $display("[TB] FAIL handshake_second cyc%0d got %b exp %b", i + 1, {dataOutA, dataValidA, busyA, frameDoneA}, exp);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    acceptA(4'b1101, 8'd3);
    checks++;
    if ({dataOutA, dataValidA, busyA} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL reset_mid_pre got %b exp 111", {dataOutA, dataValidA, busyA});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({dataOutA, dataValidA, busyA, frameDoneA} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_async got %b exp 0000", {dataOutA, dataValidA, busyA, frameDoneA});
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({dataValidA, busyA, patReadyA} !== 3'b001) begin
        errors++;
        $display("[TB] FAIL reset_mid_after cyc%0d got %b exp 001", i + 1, {dataValidA, busyA, patReadyA});
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    patValidA = 1'b0;
    patDataA  = '0;
    repCountA = '0;
    abortA    = 1'b0;
    patValidB = 1'b0;
    patDataB  = '0;
    repCountB = '0;
    abortB    = 1'b0;
    test_reset();
    test_basic();
    test_repeats();
    test_zero_default();
    test_zero_nodefault();
    test_back_to_back();
    test_abort();
    test_handshake();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
